// File: rtl/ha_array_pkg.sv
// Shared constants and types for the half-adder-array partial-product consumer.
// Rows are compressed (b, t) pairs whose value is t + (b << B_OFFSET).
package ha_array_pkg;

   localparam int unsigned NUM_ROWS  = 4;
   localparam int unsigned B_W       = 7;
   localparam int unsigned T_W       = 9;
   localparam int unsigned B_OFFSET  = 2;
   localparam int unsigned ROW_SHIFT = 2;
   localparam int unsigned OUT_W     = 16;
   localparam int unsigned ACC_W     = OUT_W + 1;
   // 511 + (127 << 2) = 1019 fits in T_W + 1 bits.
   localparam int unsigned RV_W      = T_W + 1;
   localparam int unsigned CNT_W     = $clog2(NUM_ROWS);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   typedef struct packed {
      logic [B_W-1:0] b;
      logic [T_W-1:0] t;
   } row_t;

   function automatic logic [ACC_W-1:0] row_contrib(input logic [RV_W-1:0]  rv,
                                                    input logic [CNT_W-1:0] idx);
      return ACC_W'(rv) << (ROW_SHIFT * idx);
   endfunction

endpackage

// File: rtl/ha_row_value.sv
// Collapses one compressed row into its unsigned value: rv = t + (b << B_OFFSET).
module ha_row_value
   import ha_array_pkg::*;
(
   input  logic [B_W-1:0]  b,
   input  logic [T_W-1:0]  t,
   output logic [RV_W-1:0] rv
);

   assign rv = RV_W'(t) + (RV_W'(b) << B_OFFSET);

endmodule

// File: rtl/ha_array_accumulator.sv
// Serially reduces four captured ha_array rows (one per cycle) into a 16-bit product
// plus overflow, with valid/ready handshakes on the row and product sides.
module ha_array_accumulator
   import ha_array_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [B_W-1:0] ha_array_0_b,
   input  logic [B_W-1:0] ha_array_1_b,
   input  logic [B_W-1:0] ha_array_2_b,
   input  logic [B_W-1:0] ha_array_3_b,
   input  logic [T_W-1:0] ha_array_0_t,
   input  logic [T_W-1:0] ha_array_1_t,
   input  logic [T_W-1:0] ha_array_2_t,
   input  logic [T_W-1:0] ha_array_3_t,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [OUT_W-1:0] product,
   output logic           overflow
);

   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

   state_t             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   row_cnt_q;
   logic               out_valid_q;
   row_t               rows_q [NUM_ROWS];
   row_t               in_rows [NUM_ROWS];
   row_t               sel_row;
   logic [RV_W-1:0]    sel_rv;
   logic [ACC_W-1:0]   contrib;

   always_comb begin
      in_rows[0] = '{b: ha_array_0_b, t: ha_array_0_t};
      in_rows[1] = '{b: ha_array_1_b, t: ha_array_1_t};
      in_rows[2] = '{b: ha_array_2_b, t: ha_array_2_t};
      in_rows[3] = '{b: ha_array_3_b, t: ha_array_3_t};
   end

   // A single row-value unit is shared across cycles via the row counter mux.
   assign sel_row = rows_q[row_cnt_q];

   ha_row_value u_row_value (
      .b  (sel_row.b),
      .t  (sel_row.t),
      .rv (sel_rv)
   );

   assign contrib = row_contrib(sel_rv, row_cnt_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         row_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         rows_q      <= '{default: '0};
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  rows_q    <= in_rows;
                  acc_q     <= '0;
                  row_cnt_q <= '0;
                  state_q   <= ACC;
               end
            end
            ACC: begin
               acc_q     <= acc_q + contrib;
               row_cnt_q <= row_cnt_q + 1'b1;
               if (row_cnt_q == LAST_ROW) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   // acc is frozen in DONE, so the product is stable for the whole hold period.
   assign product   = acc_q[OUT_W-1:0];
   assign overflow  = acc_q[OUT_W];

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Self-checking bench for ha_array_accumulator against an arithmetic reference model.
module tb_ha_array_accumulator;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  bv [4];
   logic [8:0]  tv [4];
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        overflow;

   int checks;
   int failures;

   ha_array_accumulator dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ha_array_0_b (bv[0]),
      .ha_array_1_b (bv[1]),
      .ha_array_2_b (bv[2]),
      .ha_array_3_b (bv[3]),
      .ha_array_0_t (tv[0]),
      .ha_array_1_t (tv[1]),
      .ha_array_2_t (tv[2]),
      .ha_array_3_t (tv[3]),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sum of (t_i + 4*b_i) * 4^i over the rows currently on the inputs.
   function automatic int unsigned ref_sum();
      int unsigned s = 0;
      for (int i = 0; i < 4; i++) s += (int'(tv[i]) + 4 * int'(bv[i])) * (4 ** i);
      return s;
   endfunction

   task automatic set_rows(input logic [6:0] b, input logic [8:0] t);
      for (int i = 0; i < 4; i++) begin
         bv[i] = b;
         tv[i] = t;
      end
   endtask

   task automatic randomize_rows();
      for (int i = 0; i < 4; i++) begin
         bv[i] = 7'($urandom);
         tv[i] = 9'($urandom);
      end
   endtask

   task automatic accept();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Edges from the accept edge until out_valid rises; 99 means it never did.
   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      if (!out_valid) n = 99;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if (out_valid !== 1'b0 || product !== 16'd0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_values: out_valid=%b product=%0d overflow=%b in_ready=%b want 0 0 0 1",
                  out_valid, product, overflow, in_ready);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic run_one(input string name, input int unsigned exp_sum);
      int n;
      accept();
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s_in_ready_acc: got %b want 0", name, in_ready);
      end
      wait_valid(n);
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL %s_latency: got %0d edges want 4", name, n);
      end
      checks++;
      if (product !== 16'(exp_sum) || overflow !== (exp_sum >= 65536)) begin
         failures++;
         $display("FAIL %s_result: product=%0d overflow=%b want %0d %b", name, product, overflow,
                  16'(exp_sum), exp_sum >= 65536);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_release: out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_single_bit();
      set_rows(7'h00, 9'h000);
      tv[0] = 9'h001;
      run_one("single_bit", 1);
   endtask

   task automatic test_row3_max();
      set_rows(7'h00, 9'h000);
      bv[3] = 7'h7F;
      tv[3] = 9'h1FF;
      run_one("row3_max", 65216);
   endtask

   task automatic test_overflow();
      set_rows(7'h7F, 9'h1FF);
      run_one("overflow", 86615);
   endtask

   task automatic test_all_zero();
      set_rows(7'h00, 9'h000);
      run_one("all_zero", 0);
   endtask

   task automatic test_back_pressure();
      int n;
      int unsigned exp;
      int bad;
      randomize_rows();
      exp = ref_sum();
      out_ready = 1'b0;
      accept();
      wait_valid(n);
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL bp_latency: got %0d edges want 4", n);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         randomize_rows();
         tick();
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 16'(exp)
             || overflow !== (exp >= 65536)) bad++;
      end
      in_valid = 1'b0;
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL bp_hold: %0d of 10 cycles unstable, want 0 (product=%0d want %0d)", bad,
                  product, 16'(exp));
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_acc();
      set_rows(7'h7F, 9'h1FF);
      out_ready = 1'b1;
      accept();
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || product !== 16'd0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_acc: out_valid=%b product=%0d overflow=%b in_ready=%b want 0 0 0 1",
                  out_valid, product, overflow, in_ready);
      end
      #1;
      rst = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_no_pulse: out_valid=%b want 0", out_valid);
      end
      randomize_rows();
      run_one("after_reset", ref_sum());
   endtask

   task automatic test_back_to_back();
      int unsigned exp [3];
      int unsigned rise [3];
      int n;
      out_ready = 1'b1;
      randomize_rows();
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp[k] = ref_sum();
         tick();
         randomize_rows();
         wait_valid(n);
         rise[k] = cyc;
         checks++;
         if (n !== 4 || product !== 16'(exp[k]) || overflow !== (exp[k] >= 65536)) begin
            failures++;
            $display("FAIL b2b_%0d: edges=%0d product=%0d overflow=%b want 4 %0d %b", k, n, product,
                     overflow, 16'(exp[k]), exp[k] >= 65536);
         end
         randomize_rows();
         tick();
      end
      in_valid = 1'b0;
      for (int k = 1; k < 3; k++) begin
         checks++;
         if (rise[k] - rise[k-1] !== 6) begin
            failures++;
            $display("FAIL b2b_interval_%0d: got %0d cycles want 6", k, rise[k] - rise[k-1]);
         end
      end
   endtask

   task automatic test_random();
      int n;
      int unsigned exp;
      int bad;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         randomize_rows();
         exp = ref_sum();
         out_ready = 1'b0;
         accept();
         wait_valid(n);
         for (int d = $urandom_range(0, 3); d > 0; d--) tick();
         if (n !== 4 || product !== 16'(exp) || overflow !== (exp >= 65536)) bad++;
         out_ready = 1'b1;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL random_sets: %0d of 20 mismatched, want 0", bad);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_rows(7'h00, 9'h000);
      test_reset();
      test_single_bit();
      test_row3_max();
      test_overflow();
      test_all_zero();
      test_back_pressure();
      test_reset_mid_acc();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ha_array_accumulator.md
Name: ha_array_accumulator

Overview:
- Consumer end of the half-adder-array partial-product interface. It takes the four compressed rows (ha_array_0..3, each a b[6:0]/t[8:0] pair) that the approximate 8x8 unsigned multiplier front end produces.
- It reduces them serially, one row per cycle, into a 16-bit product with an overflow flag.
- It sits between the partial-product generator and downstream datapath logic, with valid/ready handshakes on both sides.

Parameters:
- NUM_ROWS, 4, number of ha_array rows per operand pair.
- B_W, 7, width of each row's b vector.
- T_W, 9, width of each row's t vector.
- B_OFFSET, 2, weight offset of b[k] relative to t[k] (b[k] has weight k+2).
- ROW_SHIFT, 2, weight step between consecutive rows (row i is shifted by 2*i).
- OUT_W, 16, product width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  row set valid.
- in_ready  out  1  block can accept a row set.
- ha_array_0_b / ha_array_1_b / ha_array_2_b / ha_array_3_b  in  7 each  carry-side vectors of rows 0..3.
- ha_array_0_t / ha_array_1_t / ha_array_2_t / ha_array_3_t  in  9 each  sum-side vectors of rows 0..3.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  16  accumulated value modulo 2^16.
- overflow  out  1  true sum is >= 2^16.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Row value: rv_i = t_i + (b_i << 2), an unsigned 10-bit value. Contribution of row i = rv_i << (2*i).
- Accumulator: acc is 17 bits. product = acc[15:0]; overflow = acc[16]. Maximum sum is 1019*85 = 86615, so 17 bits never wraps.
- States: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture all 8 input vectors into registers, acc<=0, row_cnt<=0, go to ACC.
- ACC:
  - in_ready=0, out_valid=0.
  - Each cycle: acc <= acc + (rv[row_cnt] << 2*row_cnt), row_cnt <= row_cnt+1.
  - After row_cnt==NUM_ROWS-1 is added, go to DONE.
- DONE:
  - out_valid=1; product and overflow are driven from acc and held stable.
  - On out_ready, go to IDLE. Otherwise stay in DONE indefinitely.
- Latency: DONE is entered on the 4th rising edge after the accepting edge, so out_valid is high starting then.
- Throughput: with out_ready tied high, one product every 6 cycles.
- Inputs are sampled only on the accept edge. Input changes during ACC or DONE have no effect.
- in_ready is low in ACC and DONE. There is no accept in the same cycle as an out handshake.
- out_ready is ignored outside DONE.
- Reset values: state=IDLE, in_ready=1 (combinational from IDLE), out_valid=0, product=0, overflow=0, acc=0, row_cnt=0, captured rows=0.
- Reset asserted mid-ACC or in DONE: immediate return to the reset values. The in-flight result is discarded and no out_valid pulse occurs.
- All-zero rows produce product=0, overflow=0; this is a valid result, not a special case.

Decomposition:
- Shared package ha_array_pkg holds:
  - constants NUM_ROWS, B_W, T_W, B_OFFSET, ROW_SHIFT, OUT_W, and ACC_W=OUT_W+1;
  - state enum {IDLE, ACC, DONE};
  - row struct {b[B_W-1:0], t[T_W-1:0]}.
- One combinational sub-module, ha_row_value: inputs b and t, output rv = t + (b << B_OFFSET). It is instantiated once on the mux-selected row.

Test Plan:
- Single bit: row0 t=9'h001, all else 0, out_ready=1 -> product=16'd1, overflow=0, out_valid high on the 4th edge after accept.
- Row 3 max: row3 b=7'h7F, t=9'h1FF, others 0 -> product=16'd65216 (1019<<6), overflow=0.
- Overflow: all rows b=7'h7F, t=9'h1FF -> sum 86615; product=16'd21079, overflow=1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, product stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- Reset mid-ACC: assert rst after 2 ACC cycles -> immediately out_valid=0, product=0, in_ready=1. A new accept after reset yields the correct product of the new rows only.
- Back-to-back streaming: 3 random row sets with in_valid and out_ready high -> results match the reference model rv formula in order, one every 6 cycles, and late input changes have no effect.
